// File: rtl/mem_access_unit.sv
// Load/store sequencer: moves one core request to/from a byte-wide synchronous RAM,
// big-endian, one byte per cycle, plus a read-only trigger register.
module mem_access_unit #(
  parameter int unsigned           WIDTH     = 32,
  parameter int unsigned           ADDR_BITS = 17,
  parameter logic [WIDTH-1:0]      TRIG_ADDR = 'h100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_mode,
  input  logic [WIDTH-1:0]     req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  input  logic                 trigger,
  output logic                 resp_valid,
  output logic [WIDTH-1:0]     resp_rdata,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata
);

  typedef enum logic [1:0] {StIdle, StXfer, StDrain, StResp} state_e;

  state_e           state_q;
  logic [1:0]       beat_q;
  logic [1:0]       last_q;
  logic             we_q;
  logic [2:0]       mode_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] acc_q;

  logic             legal;
  logic             mmio;
  logic [1:0]       beats_m1;
  logic [WIDTH-1:0] acc_shift;

  always_comb begin
    legal    = 1'b1;
    beats_m1 = 2'd0;
    case (req_mode)
      3'b001:         beats_m1 = 2'd3;
      3'b010, 3'b100: beats_m1 = 2'd1;
      3'b011, 3'b101: beats_m1 = 2'd0;
      default:        legal    = 1'b0;
    endcase
  end

  assign mmio      = (req_addr == TRIG_ADDR);
  assign acc_shift = {acc_q[WIDTH-9:0], mem_rdata};

  // Byte idx of the right-aligned store data; idx 0 is the least-significant byte.
  function automatic logic [7:0] store_byte(input logic [WIDTH-1:0] d, input logic [1:0] idx);
    return d[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [WIDTH-1:0] extend(input logic [2:0] mode, input logic [WIDTH-1:0] a);
    case (mode)
      3'b010:  return {{(WIDTH-16){a[15]}}, a[15:0]};
      3'b011:  return {{(WIDTH-8){a[7]}}, a[7:0]};
      3'b100:  return {{(WIDTH-16){1'b0}}, a[15:0]};
      3'b101:  return {{(WIDTH-8){1'b0}}, a[7:0]};
      default: return a;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      acc_q      <= '0;
      beat_q     <= '0;
      last_q     <= '0;
      we_q       <= 1'b0;
      mode_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            mode_q    <= req_mode;
            wdata_q   <= req_wdata;
            acc_q     <= '0;
            beat_q    <= '0;
            last_q    <= beats_m1;
            req_ready <= 1'b0;
            // Illegal modes and the trigger register complete without touching the RAM.
            if (!legal || mmio) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              if (!req_we) begin
                resp_rdata <= legal ? {{(WIDTH-1){1'b0}}, trigger} : '0;
              end
            end else begin
              state_q   <= StXfer;
              mem_addr  <= req_addr[ADDR_BITS-1:0];
              mem_we    <= req_we;
              mem_wdata <= store_byte(req_wdata, beats_m1);
            end
          end
        end
        StXfer: begin
          // Read data lags its address by a cycle, so beat k delivers byte k-1.
          if (!we_q && beat_q != 2'd0) begin
            acc_q <= acc_shift;
          end
          if (beat_q == last_q) begin
            mem_we <= 1'b0;
            if (we_q) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
            end else begin
              state_q <= StDrain;
            end
          end else begin
            beat_q    <= beat_q + 2'd1;
            mem_addr  <= mem_addr + 1'b1;
            mem_wdata <= store_byte(wdata_q, last_q - beat_q - 2'd1);
          end
        end
        StDrain: begin
          acc_q      <= acc_shift;
          resp_rdata <= extend(mode_q, acc_shift);
          resp_valid <= 1'b1;
          state_q    <= StResp;
        end
        StResp: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state_q    <= StIdle;
        end
        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed test-plan cases, a reset abort and random traffic,
// checked against a byte-array memory model and per-mode latency/beat rules.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        trigger;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int checks   = 0;
  int failures = 0;

  bit [7:0]    ram    [0:(1<<17)-1];
  bit [7:0]    shadow [0:(1<<17)-1];
  logic [31:0] last_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_mode   (req_mode),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .trigger    (trigger),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Byte RAM with synchronous read (old data on read-during-write).
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one request from the IDLE cycle to its response cycle and checks it against the model.
  task automatic run_req(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic trig,
                         output int lat, output logic [31:0] rdata);
    int          n;
    bit          legal;
    bit          mmio;
    int          exp_lat;
    logic [31:0] exp_rd;
    logic [31:0] v;
    logic [16:0] a;
    logic [7:0]  b;
    logic [24:0] exp_w[$];
    logic [24:0] obs_w[$];
    logic [16:0] exp_ra[$];
    logic [16:0] obs_ra[$];
    n = (mode == 3'd1) ? 4 : (mode == 3'd2 || mode == 3'd4) ? 2 :
        (mode == 3'd3 || mode == 3'd5) ? 1 : 0;
    legal  = (n != 0);
    mmio   = (addr == 32'h100);
    exp_rd = last_rdata;
    if (!legal || mmio) begin
      exp_lat = 1;
      if (!we) exp_rd = legal ? {31'b0, trig} : 32'h0;
    end else if (we) begin
      exp_lat = n + 1;
      for (int k = 0; k < n; k++) begin
        a = addr[16:0] + 17'(k);
        b = 8'(wdata >> (8 * (n - 1 - k)));
        exp_w.push_back({a, b});
        shadow[a] = b;
      end
    end else begin
      exp_lat = n + 2;
      v = 32'h0;
      for (int k = 0; k < n; k++) begin
        a = addr[16:0] + 17'(k);
        exp_ra.push_back(a);
        v = (v << 8) | {24'h0, shadow[a]};
      end
      case (mode)
        3'd2:    exp_rd = {{16{v[15]}}, v[15:0]};
        3'd3:    exp_rd = {{24{v[7]}}, v[7:0]};
        3'd4:    exp_rd = {16'h0, v[15:0]};
        3'd5:    exp_rd = {24'h0, v[7:0]};
        default: exp_rd = v;
      endcase
    end
    last_rdata = exp_rd;

    @(negedge clk);
    chk("idle_ready", {31'b0, req_ready}, 32'd1);
    chk("resp_pulse", {31'b0, resp_valid}, 32'd0);
    req_valid = 1'b1;
    req_we    = we;
    req_mode  = mode;
    req_addr  = addr;
    req_wdata = wdata;
    trigger   = trig;
    @(posedge clk);
    lat   = 0;
    rdata = 'x;
    // req_valid stays high while busy; the unit must ignore it until it is idle again.
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(negedge clk);
      trigger = ~trig;
      if (mem_we) obs_w.push_back({mem_addr, mem_wdata});
      if (!we && legal && !mmio && c <= n) obs_ra.push_back(mem_addr);
      if (resp_valid) begin
        lat   = c;
        rdata = resp_rdata;
      end
    end
    req_valid = 1'b0;
    chk("latency", lat, exp_lat);
    chk("rdata", rdata, exp_rd);
    chk("nwrites", obs_w.size(), exp_w.size());
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++)
      chk("write_beat", {7'b0, obs_w[i]}, {7'b0, exp_w[i]});
    for (int i = 0; i < obs_ra.size() && i < exp_ra.size(); i++)
      chk("read_addr", {15'b0, obs_ra[i]}, {15'b0, exp_ra[i]});
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        r_we;
    logic [2:0]  r_mode;
    logic [31:0] r_addr;
    int          bad;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_mode  = 3'd0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    trigger   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {15'b0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", {24'b0, mem_wdata}, 32'h0);
    rst = 1'b0;

    run_req(1'b1, 3'd1, 32'h10, 32'hDEADBEEF, 1'b0, lat, rd);
    chk("sw_lat", lat, 32'd5);
    run_req(1'b0, 3'd1, 32'h10, 32'h0, 1'b0, lat, rd);
    chk("lw_val", rd, 32'hDEADBEEF);
    chk("lw_lat", lat, 32'd6);

    run_req(1'b1, 3'd2, 32'h20, 32'h0000_8001, 1'b0, lat, rd);
    chk("sh_lat", lat, 32'd3);
    run_req(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, lat, rd);
    chk("lh_val", rd, 32'hFFFF8001);
    chk("lh_lat", lat, 32'd4);
    run_req(1'b0, 3'd4, 32'h20, 32'h0, 1'b0, lat, rd);
    chk("lhu_val", rd, 32'h00008001);
    run_req(1'b0, 3'd3, 32'h20, 32'h0, 1'b0, lat, rd);
    chk("lb_val", rd, 32'hFFFFFF80);
    chk("lb_lat", lat, 32'd3);
    run_req(1'b0, 3'd5, 32'h20, 32'h0, 1'b0, lat, rd);
    chk("lbu_val", rd, 32'h00000080);

    run_req(1'b1, 3'd1, 32'h1FFFE, 32'h11223344, 1'b0, lat, rd);
    chk("sw_wrap_lat", lat, 32'd5);
    chk("rdata_hold", rd, 32'h00000080);
    run_req(1'b0, 3'd1, 32'h1FFFE, 32'h0, 1'b0, lat, rd);
    chk("lw_wrap_val", rd, 32'h11223344);

    run_req(1'b1, 3'd3, 32'h33, 32'hA5A5A55A, 1'b0, lat, rd);
    chk("sb_lat", lat, 32'd2);
    chk("sb_byte", {24'b0, ram[17'h33]}, 32'h5A);
    chk("sb_below", {24'b0, ram[17'h32]}, {24'b0, shadow[17'h32]});
    chk("sb_above", {24'b0, ram[17'h34]}, {24'b0, shadow[17'h34]});

    run_req(1'b0, 3'd1, 32'h100, 32'h0, 1'b1, lat, rd);
    chk("mmio_trig1", rd, 32'h1);
    chk("mmio_lat", lat, 32'd1);
    run_req(1'b0, 3'd5, 32'h100, 32'h0, 1'b0, lat, rd);
    chk("mmio_trig0", rd, 32'h0);
    run_req(1'b1, 3'd1, 32'h100, 32'hFFFFFFFF, 1'b1, lat, rd);
    chk("mmio_store_lat", lat, 32'd1);
    run_req(1'b1, 3'd7, 32'h44, 32'h12345678, 1'b0, lat, rd);
    chk("illegal_store_lat", lat, 32'd1);
    run_req(1'b0, 3'd0, 32'h10, 32'h0, 1'b1, lat, rd);
    chk("illegal_load_val", rd, 32'h0);

    // Reset lands at the start of cycle 3 of a word store: two bytes written, no response.
    run_req(1'b1, 3'd1, 32'h40, 32'h01020304, 1'b0, lat, rd);
    @(negedge clk);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_mode  = 3'd1;
    req_addr  = 32'h40;
    req_wdata = 32'hCAFEBABE;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_c1_resp", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("abort_c2_resp", {31'b0, resp_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_c3_resp", {31'b0, resp_valid}, 32'd0);
    chk("abort_c3_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    chk("abort_c4_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_c4_resp", {31'b0, resp_valid}, 32'd0);
    chk("abort_bytes", {ram[17'h40], ram[17'h41], ram[17'h42], ram[17'h43]}, 32'hCAFE0304);
    chk("abort_rdata", resp_rdata, 32'h0);
    shadow[17'h40] = 8'hCA;
    shadow[17'h41] = 8'hFE;
    last_rdata     = 32'h0;

    for (int i = 0; i < 120; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_mode = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       r_addr = 32'h1FFF0 + $urandom_range(0, 15);
        1:       r_addr = $urandom_range(0, 63);
        2:       r_addr = {15'($urandom_range(1, 32767)), 17'($urandom_range(0, 63))};
        default: r_addr = 32'h100;
      endcase
      if (r_addr == 32'h100 && (r_mode == 3'd0 || r_mode > 3'd5)) r_mode = 3'd1;
      run_req(r_we, r_mode, r_addr, $urandom, 1'($urandom_range(0, 1)), lat, rd);
    end

    bad = 0;
    for (int i = 0; i < (1 << 17); i++) if (ram[i] !== shadow[i]) bad++;
    chk("ram_final", bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
